control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit directly upstream of Datapath: drives every control strobe the datapath consumes.
//  Sequences fetch (T0-T2), then decodes IR and runs the execute steps (T3-T7) for ALU, immediate, ld, st, nop, halt.
//  Stretches memory steps until Mem_ready, aborts on memory timeout, and halts on Stop or the halt opcode.
// PARAMETERS
//  TIMEOUT  16  max cycles a memory step may wait for Mem_ready before fault (>=2)
//  OPW      5   opcode width, IR[31:27]
//  ALUW     4   ALU_op width
// PORTS
//  Clock      in   1   rising-edge clock
//  Reset      in   1   asynchronous, active-high reset
//  IR         in   32  instruction register; opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15] C[18:0]
//  Mem_ready  in   1   memory completes current Read/Write this cycle
//  Stop       in   1   request halt at next instruction boundary
//  PCout,Zlowout,MDRout,BAout,Cout         out 1  bus drive strobes
//  MARin,Zin,PCin,MDRin,IRin,Yin,IncPC     out 1  register load / PC increment strobes
//  Read,Write                              out 1  memory strobes
//  Gra,Grb,Grc,Rin,Rout                    out 1  register-file select/encode controls
//  ALU_op     out  4   0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHL,6 ROR,7 ROL
//  Run        out  1   1 while sequencing; 0 in reset/HALT
//  Mem_fault  out  1   sticky: memory timeout occurred
//  Illegal    out  1   sticky: undefined opcode trapped (ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  - Moore FSM: state register on posedge Clock; all strobes decoded from state only, held the whole state.
//  - Reset (async): state=RST, every output 0 (Run, ALU_op, sticky flags incl.) immediately, even mid-instruction.
//    First edge with Reset low: RST->T0.
//  - Fetch: T0 PCout MARin IncPC Zin | T1 Zlowout PCin Read MDRin (wait) | T2 MDRout IRin -> T3.
//  - Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111,
//    shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, nop 11010, halt 11011.
//  - R-type: T3 Grb Rout Yin | T4 Grc Rout Zin ALU_op=op | T5 Zlowout Gra Rin -> T0.
//  - Imm:    T3 Grb Rout Yin | T4 Cout Zin ALU_op=ADD/AND/OR | T5 Zlowout Gra Rin -> T0.
//  - ld: T3 Grb BAout Yin | T4 Cout Zin ALU_op=ADD | T5 Zlowout MARin | T6 Read MDRin (wait) | T7 MDRout Gra Rin.
//  - st: T3-T5 as ld | T6 Gra Rout MDRin | T7 Write (wait) -> T0.
//  - nop: T3 no strobes -> T0. halt: T3 -> HALT.
//  - ALU_op = 0 in every state except T4.
//  - Wait states (T1, ld T6, st T7): advance on edge where Mem_ready=1 (zero-wait if high in first cycle);
//    else stay, strobes held. Wait counter cleared on entry, +1 per cycle with Mem_ready=0.
//    Counter==TIMEOUT-1 and Mem_ready=0 -> HALT, Mem_fault=1. Mem_ready=1 on that same edge wins (advance).
//  - Stop: latched into stop_pend on any edge; T0 entry with stop_pend=1 goes to HALT instead.
//    The current instruction always completes. halt opcode + Stop together -> HALT, no conflict.
//  - HALT: all strobes 0, Run=0, exited only by Reset. Run=1 in every state except RST/HALT.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: undefined opcode at T3 -> HALT, Illegal=1 (sticky).
//  Not defined: undefined opcode executes as nop (T3 -> T0); Illegal tied 0.
// TESTING
//  1 Mem_ready=1, IR=0x2A1B8000 (and R4,R3,R7): T0..T5 strobes as listed; T4 ALU_op=2 Grc Rout Zin; T0 re-entered on 7th edge.
//  2 T1 with Mem_ready low 3 cycles: Read/MDRin high 4 cycles, T2 on the 4th edge; Mem_fault stays 0.
//  3 Mem_ready held 0 in T1: HALT after TIMEOUT(16) cycles, Mem_fault=1, Run=0, Read=0.
//    Reset then restarts at T0 with Mem_fault=0.
//  4 IR=0x00900010 (ld R1,0x10(R2)): T3 BAout Grb Yin, T4 Cout ALU_op=0, T5 MARin, T6 Read MDRin, T7 MDRout Gra Rin.
//  5 Stop pulsed 1 cycle during T4 of add: T5 completes, then HALT, Run=0, no further PCout/Read.
//    Reset asserted mid-T1: all outputs 0 before next edge.
//  6 IR opcode 11111: with CTRL_ILLEGAL_TRAP_EN -> HALT, Illegal=1; without -> back to T0, Illegal=0.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control interface between the hardwired control sequencer and the datapath.
// The master is the sequencer. It reads IR, Mem_ready and Stop, and drives every control strobe.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        Stop;

  logic PCout, Zlowout, MDRout, BAout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout;
  logic [3:0] ALU_op;
  logic Run, Mem_fault, Illegal;

  modport master (
    input  IR, Mem_ready, Stop,
    output PCout, Zlowout, MDRout, BAout, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
    output Read, Write, Gra, Grb, Grc, Rin, Rout,
    output ALU_op, Run, Mem_fault, Illegal
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  PCout, Zlowout, MDRout, BAout, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
    input  Read, Write, Gra, Grb, Grc, Rin, Rout,
    input  ALU_op, Run, Mem_fault, Illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, then the execute steps T3-T7, with memory wait/timeout and halt.
// Optional macro CTRL_ILLEGAL_TRAP_EN: an undefined opcode halts and sets Illegal; otherwise it runs as a nop.
module control_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned OPW     = 5,
  parameter int unsigned ALUW    = 4
) (
  input logic clk,
  input logic rst,
  control_sequencer_if.master bus
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
  localparam logic [ALUW-1:0] ALU_AND = ALUW'(2);
  localparam logic [ALUW-1:0] ALU_OR  = ALUW'(3);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t          state;
  state_t          boundary;
  state_t          wait_next;
  logic [CW-1:0]   cnt;
  logic            stop_pend;
  logic            mem_fault;
  logic            illegal;
  logic            in_wait;
  logic [OPW-1:0]  op;
  logic            is_ld, is_st, is_rtype, is_imm, is_nop, is_halt, known;
  logic [ALUW-1:0] alu;
  logic            unused_ir;

  // IR is the datapath's instruction register: it is valid from T3 until the next IRin.
  assign op        = bus.IR[31 -: OPW];
  assign unused_ir = ^bus.IR[31-OPW:0];
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign is_rtype  = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_nop    = (op == OP_NOP);
  assign is_halt   = (op == OP_HALT);
  assign known     = is_ld | is_st | is_rtype | is_imm | is_nop | is_halt;

  // Instruction boundary: a pending stop, or one that arrives on this edge, halts here.
  assign boundary  = (stop_pend | bus.Stop) ? S_HALT : S_T0;
  assign in_wait   = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
  assign wait_next = (state == S_T1) ? S_T2 : (state == S_T6) ? S_T7 : boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST;
      cnt       <= '0;
      stop_pend <= 1'b0;
      mem_fault <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      stop_pend <= stop_pend | bus.Stop;
      cnt       <= '0;
      if (in_wait) begin
        // Mem_ready on the final allowed cycle still wins over the timeout.
        if (bus.Mem_ready) begin
          state <= wait_next;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state     <= S_HALT;
          mem_fault <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        case (state)
          S_RST:  state <= boundary;
          S_T0:   state <= S_T1;
          S_T2:   state <= S_T3;
          S_T3: begin
            if (is_halt) begin
              state <= S_HALT;
            end else if (is_nop) begin
              state <= boundary;
            end else if (!known) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              state   <= S_HALT;
              illegal <= 1'b1;
`else
              state <= boundary;
`endif
            end else begin
              state <= S_T4;
            end
          end
          S_T4:   state <= S_T5;
          S_T5:   state <= (is_ld || is_st) ? S_T6 : boundary;
          S_T6:   state <= S_T7;
          S_T7:   state <= boundary;
          default: state <= S_HALT;
        endcase
      end
    end
  end

  always_comb begin
    alu = ALU_ADD;
    case (op)
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      default: alu = is_rtype ? ALUW'(op - OP_ADD) : ALU_ADD;
    endcase
  end

  // Strobes decode the current step; only T3-T7 look at the instruction class.
  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.BAout = 1'b0; bus.Cout = 1'b0;
    bus.MARin = 1'b0; bus.Zin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.ALU_op = '0;
    case (state)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: begin
        if (is_rtype || is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_ld || is_st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end
      end
      S_T4: begin
        bus.Zin    = 1'b1;
        bus.ALU_op = 4'(alu);
        if (is_rtype) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1;
        end else begin
          bus.Cout = 1'b1;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_ld || is_st) begin
          bus.MARin = 1'b1;
        end else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (is_ld) bus.Read = 1'b1;
        else begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        else bus.Write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Run       = (state != S_RST) && (state != S_HALT);
  assign bus.Mem_fault = mem_fault;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.Illegal   = illegal;
`else
  assign bus.Illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-cycle vector table plus hand-written wait, timeout, stop,
// reset and illegal-opcode sequences.
module tb_control_sequencer;

  localparam logic [18:0] PCO  = 19'h40000, ZLO  = 19'h20000, MDRO = 19'h10000, BAO  = 19'h08000;
  localparam logic [18:0] COUT = 19'h04000, MARI = 19'h02000, ZIN  = 19'h01000, PCI  = 19'h00800;
  localparam logic [18:0] MDRI = 19'h00400, IRI  = 19'h00200, YIN  = 19'h00100, INC  = 19'h00080;
  localparam logic [18:0] RD   = 19'h00040, WR   = 19'h00020, GRA  = 19'h00010, GRB  = 19'h00008;
  localparam logic [18:0] GRC  = 19'h00004, RIN  = 19'h00002, ROUT = 19'h00001;

  localparam logic [18:0] ST0  = PCO | MARI | INC | ZIN;
  localparam logic [18:0] ST1  = ZLO | PCI | RD | MDRI;
  localparam logic [18:0] ST2  = MDRO | IRI;
  localparam logic [18:0] ST3R = GRB | ROUT | YIN;
  localparam logic [18:0] ST3M = GRB | BAO | YIN;
  localparam logic [18:0] ST4R = GRC | ROUT | ZIN;
  localparam logic [18:0] ST4I = COUT | ZIN;
  localparam logic [18:0] ST5R = ZLO | GRA | RIN;
  localparam logic [18:0] ST5M = ZLO | MARI;
  localparam logic [18:0] ST6L = RD | MDRI;
  localparam logic [18:0] ST6S = GRA | ROUT | MDRI;
  localparam logic [18:0] ST7L = MDRO | GRA | RIN;
  localparam logic [18:0] ST7S = WR;

  localparam logic [31:0] I_AND  = 32'h2A1B8000, I_LD   = 32'h00900010, I_ST  = 32'h10900010;
  localparam logic [31:0] I_ADDI = 32'h58900005, I_ORI  = 32'h68000000, I_NOP = 32'hD0000000;
  localparam logic [31:0] I_SHL  = 32'h40000000, I_ROL  = 32'h50000000, I_HLT = 32'hD8000000;
  localparam logic [31:0] I_ADD  = 32'h18000000, I_BAD  = 32'hF8000000;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        mr;
    logic        stop;
    logic [25:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  logic [25:0] act;

  always #5 clk = ~clk;

  control_sequencer_if bus();

  control_sequencer #(.TIMEOUT(16), .OPW(5), .ALUW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign act = {bus.PCout, bus.Zlowout, bus.MDRout, bus.BAout, bus.Cout, bus.MARin, bus.Zin,
                bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read, bus.Write,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                bus.ALU_op, bus.Run, bus.Mem_fault, bus.Illegal};

  function automatic logic [25:0] e(input logic [18:0] s, input logic [3:0] a,
                                    input logic run, input logic flt, input logic ill);
    return {s, a, run, flt, ill};
  endfunction

  task automatic check(input string name, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] ir, input logic mr, input logic [25:0] exp);
    vec_t v;
    v.rst = r; v.ir = ir; v.mr = mr; v.stop = 1'b0; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic fetch_rows(input logic [31:0] ir);
    add(1'b0, ir, 1'b1, e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, ir, 1'b1, e(ST1, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, ir, 1'b1, e(ST2, 4'd0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Leaves the DUT in RST with reset just released; the next edge enters T0.
  task automatic reset_go(input logic [31:0] ir);
    @(negedge clk);
    rst = 1'b1; bus.IR = ir; bus.Mem_ready = 1'b1; bus.Stop = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_fetch(input string tag);
    cyc(); #1 check({tag, "_t0"}, e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); #1 check({tag, "_t1"}, e(ST1, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); #1 check({tag, "_t2"}, e(ST2, 4'd0, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    rst = 1'b1; bus.IR = '0; bus.Mem_ready = 1'b1; bus.Stop = 1'b0;

    // Per-cycle table: each row is the step the DUT should be in while those inputs are applied.
    add(1'b1, I_AND, 1'b1, e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, I_AND, 1'b1, e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    fetch_rows(I_AND);
    add(1'b0, I_AND, 1'b1, e(ST3R, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_AND, 1'b1, e(ST4R, 4'd2, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_AND, 1'b1, e(ST5R, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_LD);
    add(1'b0, I_LD, 1'b1, e(ST3M, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_LD, 1'b1, e(ST4I, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_LD, 1'b1, e(ST5M, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_LD, 1'b0, e(ST6L, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_LD, 1'b1, e(ST6L, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_LD, 1'b1, e(ST7L, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_ST);
    add(1'b0, I_ST, 1'b1, e(ST3M, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ST, 1'b1, e(ST4I, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ST, 1'b1, e(ST5M, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ST, 1'b1, e(ST6S, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ST, 1'b0, e(ST7S, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ST, 1'b1, e(ST7S, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_ADDI);
    add(1'b0, I_ADDI, 1'b1, e(ST3R, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ADDI, 1'b1, e(ST4I, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ADDI, 1'b1, e(ST5R, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_ORI);
    add(1'b0, I_ORI, 1'b1, e(ST3R, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ORI, 1'b1, e(ST4I, 4'd3, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ORI, 1'b1, e(ST5R, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_NOP);
    add(1'b0, I_NOP, 1'b1, e(19'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_SHL);
    add(1'b0, I_SHL, 1'b1, e(ST3R, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_SHL, 1'b1, e(ST4R, 4'd5, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_SHL, 1'b1, e(ST5R, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_ROL);
    add(1'b0, I_ROL, 1'b1, e(ST3R, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ROL, 1'b1, e(ST4R, 4'd7, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_ROL, 1'b1, e(ST5R, 4'd0, 1'b1, 1'b0, 1'b0));
    fetch_rows(I_HLT);
    add(1'b0, I_HLT, 1'b1, e(19'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    add(1'b0, I_HLT, 1'b1, e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    add(1'b0, I_HLT, 1'b1, e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; bus.IR = tbl[i].ir; bus.Mem_ready = tbl[i].mr; bus.Stop = tbl[i].stop;
      #1 check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Fetch read stretched by three not-ready cycles.
    reset_go(I_AND);
    cyc(); #1 check("w3_t0", e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      cyc(); bus.Mem_ready = (k == 3);
      #1 check($sformatf("w3_t1_%0d", k), e(ST1, 4'd0, 1'b1, 1'b0, 1'b0));
    end
    cyc(); #1 check("w3_t2", e(ST2, 4'd0, 1'b1, 1'b0, 1'b0));

    // Mem_ready arriving on the last allowed cycle still advances.
    reset_go(I_AND);
    cyc(); #1 check("edge_t0", e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 16; k++) begin
      cyc(); bus.Mem_ready = (k == 15);
      #1 check($sformatf("edge_t1_%0d", k), e(ST1, 4'd0, 1'b1, 1'b0, 1'b0));
    end
    cyc(); #1 check("edge_t2", e(ST2, 4'd0, 1'b1, 1'b0, 1'b0));

    // Memory timeout in fetch, then reset recovery.
    reset_go(I_AND);
    cyc(); #1 check("to_t0", e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 16; k++) begin
      cyc(); bus.Mem_ready = 1'b0;
      #1 check($sformatf("to_t1_%0d", k), e(ST1, 4'd0, 1'b1, 1'b0, 1'b0));
    end
    cyc(); #1 check("to_halt", e(19'h0, 4'd0, 1'b0, 1'b1, 1'b0));
    cyc(); bus.Mem_ready = 1'b1;
    #1 check("to_halt_hold", e(19'h0, 4'd0, 1'b0, 1'b1, 1'b0));
    rst = 1'b1;
    #1 check("to_rst", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    cyc(); rst = 1'b0;
    cyc(); #1 check("to_restart", e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));

    // Stop pulsed during T4 of add: instruction completes, then halt.
    reset_go(I_ADD);
    run_fetch("stop");
    cyc(); #1 check("stop_t3", e(ST3R, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); bus.Stop = 1'b1;
    #1 check("stop_t4", e(ST4R, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); bus.Stop = 1'b0;
    #1 check("stop_t5", e(ST5R, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); #1 check("stop_halt", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    cyc(); #1 check("stop_halt2", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset in the middle of T1.
    reset_go(I_AND);
    cyc(); #1 check("ar_t0", e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); #1 check("ar_t1", e(ST1, 4'd0, 1'b1, 1'b0, 1'b0));
    #1 rst = 1'b1;
    #1 check("ar_zero", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));

    // halt opcode together with Stop.
    reset_go(I_HLT);
    run_fetch("hs");
    cyc(); bus.Stop = 1'b1;
    #1 check("hs_t3", e(19'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc(); bus.Stop = 1'b0;
    #1 check("hs_halt", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));

    // Undefined opcode 11111.
    reset_go(I_BAD);
    run_fetch("ill");
    cyc(); #1 check("ill_t3", e(19'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    cyc();
`ifdef CTRL_ILLEGAL_TRAP_EN
    #1 check("ill_trap", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b1));
    rst = 1'b1;
    #1 check("ill_rst", e(19'h0, 4'd0, 1'b0, 1'b0, 1'b0));
`else
    #1 check("ill_nop", e(ST0, 4'd0, 1'b1, 1'b0, 1'b0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
